// File: rtl/lut_const_div_16bit_if.sv
// Handshake bundle for lut_const_div_16bit; the producer/consumer side uses master, the divider slave.
// exact_out exists only when LUT_DIV_EXACT_EN is defined.
interface lut_const_div_16bit_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q_out;
    logic [7:0]  r_out;
    logic        busy;
`ifdef LUT_DIV_EXACT_EN
    logic        exact_out;

    modport master (
        output in_valid, c_in, out_ready,
        input  in_ready, out_valid, q_out, r_out, busy, exact_out
    );
    modport slave (
        input  in_valid, c_in, out_ready,
        output in_ready, out_valid, q_out, r_out, busy, exact_out
    );
`else
    modport master (
        output in_valid, c_in, out_ready,
        input  in_ready, out_valid, q_out, r_out, busy
    );
    modport slave (
        input  in_valid, c_in, out_ready,
        output in_ready, out_valid, q_out, r_out, busy
    );
`endif
endinterface

// File: rtl/lut_const_div_16bit.sv
// Divide a 16-bit dividend by constant A_const: four radix-16 restoring steps using a k*A_const LUT.
// Optional macro LUT_DIV_EXACT_EN adds exact_out (remainder == 0), registered with r_out.
module lut_const_div_16bit #(
    parameter int unsigned A_const = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lut_const_div_16bit_if.slave   bus
);

    if (A_const < 1 || A_const > 255) begin : g_bad_divisor
        $error("lut_const_div_16bit: A_const must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] sreg_q, sreg_d;
    logic [11:0] rem_q, rem_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] q_q, q_d;
    logic [7:0]  r_q, r_d;
    logic        out_valid_q, out_valid_d;

    logic [11:0] mult [16];
    logic [15:0] ge;
    logic [11:0] t;
    logic [3:0]  k_sel;
    logic [11:0] rem_next;
    logic        unused_rem;

    // R < A_const <= 255 keeps T below 16*A_const, so k stays within 0..15.
    assign t = {rem_q[7:0], sreg_q[15:12]};
    assign unused_rem = ^rem_q[11:8];

    for (genvar i = 0; i < 16; i++) begin : g_lut
        assign mult[i] = 12'(i * A_const);
        assign ge[i]   = (t >= mult[i]);
    end

    // Multiples are monotonic, so the highest passing compare is the quotient digit.
    always_comb begin
        k_sel = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (ge[i]) k_sel = 4'(i);
        end
    end

    assign rem_next = t - mult[k_sel];

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sreg_d  = bus.c_in;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                // Dividend nibbles shift out the top while quotient digits fill the bottom.
                sreg_d = {sreg_q[11:0], k_sel};
                rem_d  = rem_next;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    q_d         = {sreg_q[11:0], k_sel};
                    r_d         = rem_next[7:0];
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef LUT_DIV_EXACT_EN
    logic exact_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_q <= 1'b0;
        end else if (state_q == StDiv && cnt_q == 2'd3) begin
            exact_q <= (rem_next == 12'd0);
        end
    end

    assign bus.exact_out = exact_q;
`endif

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.q_out     = q_q;
    assign bus.r_out     = r_q;

endmodule

// File: tb/tb_lut_const_div_16bit.sv
// Directed bench: five dividers (A_const = 2, 7, 13, 255, 1) sharing clock, reset, c_in and out_ready.
module tb_lut_const_div_16bit;

    localparam int NumDut = 5;
    localparam logic [39:0] Divs = {8'd1, 8'd255, 8'd13, 8'd7, 8'd2};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [NumDut-1:0] in_valid;
    logic [15:0] c_in;
    logic        out_ready;

    logic [NumDut-1:0] in_ready;
    logic [NumDut-1:0] out_valid;
    logic [NumDut-1:0] busy_v;
    logic [NumDut-1:0] ex_v;
    logic [15:0] q_v [NumDut];
    logic [7:0]  r_v [NumDut];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NumDut; g++) begin : g_dut
        lut_const_div_16bit_if u_if ();

        lut_const_div_16bit #(
            .A_const(int'(Divs[g*8 +: 8]))
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (u_if.slave)
        );

        assign u_if.in_valid  = in_valid[g];
        assign u_if.c_in      = c_in;
        assign u_if.out_ready = out_ready;
        assign in_ready[g]    = u_if.in_ready;
        assign out_valid[g]   = u_if.out_valid;
        assign busy_v[g]      = u_if.busy;
        assign q_v[g]         = u_if.q_out;
        assign r_v[g]         = u_if.r_out;
`ifdef LUT_DIV_EXACT_EN
        assign ex_v[g]        = u_if.exact_out;
`else
        assign ex_v[g]        = 1'b0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called between edges; accept happens on the next rising edge.
    task automatic run_op(input int g, input logic [15:0] c, output logic [15:0] q,
                          output logic [7:0] r, output logic ex, output int lat);
        check("idle_in_ready", 32'(in_ready[g]), 32'd1);
        c_in        = c;
        in_valid[g] = 1'b1;
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
        lat = 0;
        while (!out_valid[g] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        q = q_v[g];
        r = r_v[g];
        ex = ex_v[g];
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic vec(input string tag, input int g, input logic [15:0] c,
                       input logic [15:0] eq, input logic [7:0] er);
        logic [15:0] q;
        logic [7:0]  r;
        logic        ex;
        int          lat;
        run_op(g, c, q, r, ex, lat);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_q"}, 32'(q), 32'(eq));
        check({tag, "_r"}, 32'(r), 32'(er));
`ifdef LUT_DIV_EXACT_EN
        check({tag, "_exact"}, 32'(ex), (er == 8'd0) ? 32'd1 : 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] q;
        logic [7:0]  r;
        logic        ex;
        int          lat;

        rst_n     = 1'b0;
        in_valid  = '0;
        c_in      = '0;
        out_ready = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'h1f);
        check("rst_busy", 32'(busy_v), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q_v[0]), 32'd0);
        check("rst_r", 32'(r_v[1]), 32'd0);
        check("rst_exact", 32'(ex_v), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        vec("a2_30", 0, 16'd30, 16'd15, 8'd0);
        vec("a7_ffff", 1, 16'hffff, 16'd9362, 8'd1);
        vec("a13_1000", 2, 16'd1000, 16'd76, 8'd12);
        vec("a255_0", 3, 16'd0, 16'd0, 8'd0);
        vec("a1_ffff", 4, 16'hffff, 16'hffff, 8'd0);
        vec("a1_1234", 4, 16'h1234, 16'h1234, 8'd0);
        vec("a255_ffff", 3, 16'hffff, 16'd257, 8'd0);
        vec("a2_ffff", 0, 16'hffff, 16'd32767, 8'd1);
        vec("a13_ffff", 2, 16'hffff, 16'd5041, 8'd2);

        // Backpressure: hold DONE for three cycles while offering a new dividend.
        c_in        = 16'd1000;
        in_valid[2] = 1'b1;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_out_valid", 32'(out_valid[2]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid[2] = 1'b1;
            c_in        = 16'h1234;
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid[2]), 32'd1);
            check("bp_hold_q", 32'(q_v[2]), 32'd76);
            check("bp_hold_r", 32'(r_v[2]), 32'd12);
            check("bp_in_ready", 32'(in_ready[2]), 32'd0);
        end
        in_valid[2] = 1'b0;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_idle_ready", 32'(in_ready[2]), 32'd1);
        check("bp_cleared_valid", 32'(out_valid[2]), 32'd0);
        check("bp_busy", 32'(busy_v[2]), 32'd0);
        check("bp_q_kept", 32'(q_v[2]), 32'd76);
        check("bp_r_kept", 32'(r_v[2]), 32'd12);
        vec("a13_after_bp", 2, 16'd26, 16'd2, 8'd0);

        // Reset during the third DIV cycle.
        c_in        = 16'd30;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy_before", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("mid_rst_q", 32'(q_v[0]), 32'd0);
        check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        #2 rst_n = 1'b1;
        vec("a2_100_after_rst", 0, 16'd100, 16'd50, 8'd0);

        // Round trip through the constant multiplier.
        for (int x = 0; x < 256; x++) begin
            run_op(3, 16'(x * 255), q, r, ex, lat);
            check("rt255_q", 32'(q), 32'(x));
            check("rt255_r", 32'(r), 32'd0);
            run_op(1, 16'(x * 7), q, r, ex, lat);
            check("rt7_q", 32'(q), 32'(x));
            check("rt7_r", 32'(r), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
